// File: rtl/reg_dump_ctrl.sv
// Debug read-out engine: walks register indices FIRST_REG..LAST_REG through one read port and streams each value.
// Define REG_DUMP_CHECKSUM_EN to append an XOR checksum word after the last register of each dump.
module reg_dump_ctrl #(
    parameter int FIRST_REG  = 0,
    parameter int LAST_REG   = 31,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic [4:0]            rd_sel,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [4:0]            out_index,
    output logic                  out_last
);

    localparam logic [4:0] FIRST_IDX = 5'(FIRST_REG);
    localparam logic [4:0] LAST_IDX  = 5'(LAST_REG);

`ifdef REG_DUMP_CHECKSUM_EN
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_PRESENT = 3'd2,
        ST_FINISH  = 3'd3,
        ST_CHKSUM  = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_PRESENT = 3'd2,
        ST_FINISH  = 3'd3
    } state_t;
`endif

    state_t                  state_r;
    logic [4:0]              idx_r;
    logic                    busy_r;
    logic                    done_r;
    logic                    valid_r;
    logic                    last_r;
    logic [DATA_WIDTH-1:0]   data_r;
    logic [4:0]              index_r;
    logic                    handshake_s;
    logic                    at_last_s;

`ifdef REG_DUMP_CHECKSUM_EN
    logic [DATA_WIDTH-1:0]   acc_r;

    function automatic logic [DATA_WIDTH-1:0] chk_fold(
        input logic [DATA_WIDTH-1:0] acc,
        input logic [DATA_WIDTH-1:0] word
    );
        return acc ^ word;
    endfunction
`endif

    assign handshake_s = valid_r && out_ready;
    assign at_last_s   = (idx_r == LAST_IDX);

    assign busy      = busy_r;
    assign done      = done_r;
    assign rd_sel    = idx_r;
    assign out_valid = valid_r;
    assign out_data  = data_r;
    assign out_index = index_r;
    assign out_last  = last_r;

    // Dump sequencer; busy_r is high exactly in the states where abort is honoured.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
            idx_r   <= FIRST_IDX;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            valid_r <= 1'b0;
            last_r  <= 1'b0;
            data_r  <= {DATA_WIDTH{1'b0}};
            index_r <= 5'd0;
`ifdef REG_DUMP_CHECKSUM_EN
            acc_r   <= {DATA_WIDTH{1'b0}};
`endif
        end else begin
            done_r <= 1'b0;
            if (abort && busy_r) begin
                state_r <= ST_IDLE;
                valid_r <= 1'b0;
                last_r  <= 1'b0;
                busy_r  <= 1'b0;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (start) begin
                            state_r <= ST_FETCH;
                            idx_r   <= FIRST_IDX;
                            busy_r  <= 1'b1;
`ifdef REG_DUMP_CHECKSUM_EN
                            acc_r   <= {DATA_WIDTH{1'b0}};
`endif
                        end
                    end
                    ST_FETCH: begin
                        data_r  <= rd_data;
                        index_r <= idx_r;
                        valid_r <= 1'b1;
`ifdef REG_DUMP_CHECKSUM_EN
                        last_r  <= 1'b0;
                        acc_r   <= chk_fold(acc_r, rd_data);
`else
                        last_r  <= at_last_s;
`endif
                        state_r <= ST_PRESENT;
                    end
                    ST_PRESENT: begin
                        if (handshake_s) begin
                            if (!at_last_s) begin
                                if (idx_r < LAST_IDX) begin
                                    idx_r <= idx_r + 5'd1;
                                end
                                valid_r <= 1'b0;
                                state_r <= ST_FETCH;
                            end else begin
`ifdef REG_DUMP_CHECKSUM_EN
                                // valid stays high: the checksum word follows back-to-back
                                data_r  <= acc_r;
                                index_r <= 5'd0;
                                last_r  <= 1'b1;
                                state_r <= ST_CHKSUM;
`else
                                valid_r <= 1'b0;
                                last_r  <= 1'b0;
                                busy_r  <= 1'b0;
                                done_r  <= 1'b1;
                                state_r <= ST_FINISH;
`endif
                            end
                        end
                    end
`ifdef REG_DUMP_CHECKSUM_EN
                    ST_CHKSUM: begin
                        if (handshake_s) begin
                            valid_r <= 1'b0;
                            last_r  <= 1'b0;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                            state_r <= ST_FINISH;
                        end
                    end
`endif
                    ST_FINISH: begin
                        state_r <= ST_IDLE;
                    end
                    default: begin
                        state_r <= ST_IDLE;
                        valid_r <= 1'b0;
                        last_r  <= 1'b0;
                        busy_r  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_reg_dump_ctrl.sv
// Self-checking bench for reg_dump_ctrl: register-file model, queue-based expected word stream per dump.
module tb_reg_dump_ctrl;

    logic        clock = 1'b0;
    logic        reset, start, abort, ready, sel_b;
    logic [31:0] regs [32];

    logic        a_start, a_ready, a_busy, a_done, a_valid, a_last;
    logic [4:0]  a_sel, a_index;
    logic [31:0] a_rd, a_data;
    logic        b_start, b_ready, b_busy, b_done, b_valid, b_last;
    logic [4:0]  b_sel, b_index;
    logic [31:0] b_rd, b_data;

    logic        m_busy, m_done, m_valid, m_last;
    logic [4:0]  m_index, m_sel;
    logic [31:0] m_data;

    int tests = 0;
    int fails = 0;
    int stall_idx = -1;
    int abort_idx = -1;
    int poke_idx  = -1;
    bit rand_ready = 1'b0;

    always #5 clock = ~clock;

    assign a_start = start & ~sel_b;
    assign b_start = start & sel_b;
    assign a_ready = ready & ~sel_b;
    assign b_ready = ready & sel_b;

    always_comb a_rd = (a_sel == 5'd0) ? 32'd0 : regs[a_sel];
    always_comb b_rd = (b_sel == 5'd0) ? 32'd0 : regs[b_sel];

    assign m_busy  = sel_b ? b_busy  : a_busy;
    assign m_done  = sel_b ? b_done  : a_done;
    assign m_valid = sel_b ? b_valid : a_valid;
    assign m_last  = sel_b ? b_last  : a_last;
    assign m_index = sel_b ? b_index : a_index;
    assign m_data  = sel_b ? b_data  : a_data;
    assign m_sel   = sel_b ? b_sel   : a_sel;

    reg_dump_ctrl #(.FIRST_REG(0), .LAST_REG(31), .DATA_WIDTH(32)) dut (
        .clock(clock), .reset(reset), .start(a_start), .abort(abort),
        .busy(a_busy), .done(a_done), .rd_sel(a_sel), .rd_data(a_rd),
        .out_valid(a_valid), .out_ready(a_ready), .out_data(a_data),
        .out_index(a_index), .out_last(a_last)
    );

    reg_dump_ctrl #(.FIRST_REG(10), .LAST_REG(12), .DATA_WIDTH(32)) dut_b (
        .clock(clock), .reset(reset), .start(b_start), .abort(abort),
        .busy(b_busy), .done(b_done), .rd_sel(b_sel), .rd_data(b_rd),
        .out_valid(b_valid), .out_ready(b_ready), .out_data(b_data),
        .out_index(b_index), .out_last(b_last)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One dump on the selected instance, checked word by word against a list built from the register model.
    task automatic run_dump(input string name, input int first, input int last);
        logic [31:0] exp_d [$];
        logic [4:0]  exp_i [$];
        logic        exp_l [$];
        logic [31:0] acc, val, old;
        int cyc, last_hs, done_cyc, stall_left, expect_hs;
        bit stalled, poked, rdy, overrun;
        acc = 32'd0; cyc = 0; last_hs = -1; done_cyc = -1; stall_left = 0;
        stalled = 1'b0; poked = 1'b0; overrun = 1'b0;
        for (int i = first; i <= last; i++) begin
            val = (i == 0) ? 32'd0 : regs[i];
            exp_d.push_back(val);
            exp_i.push_back(5'(i));
            exp_l.push_back(i == last);
            acc ^= val;
        end
`ifdef REG_DUMP_CHECKSUM_EN
        exp_l[exp_l.size()-1] = 1'b0;
        exp_d.push_back(acc);
        exp_i.push_back(5'd0);
        exp_l.push_back(1'b1);
        expect_hs = 2 * (last - first + 1) + 1;
`else
        expect_hs = 2 * (last - first + 1);
`endif
        if (stall_idx >= 0) expect_hs += 10;
        start = 1'b1;
        step();
        start = 1'b0;
        check({name, " busy after start"}, 32'(m_busy), 32'd1);
        while (cyc < 400 && done_cyc < 0 && !overrun) begin
            if (m_done === 1'b1) begin
                done_cyc = cyc;
            end else begin
                rdy = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
                if (m_valid === 1'b1) begin
                    if (exp_d.size() == 0) begin
                        check({name, " extra word"}, 32'(m_index), 32'hFFFF_FFFF);
                        overrun = 1'b1;
                    end else begin
                        if (stall_idx >= 0 && m_index == stall_idx && !stalled) begin
                            stalled = 1'b1;
                            stall_left = 10;
                        end
                        if (stall_left > 0) begin
                            rdy = 1'b0;
                            stall_left--;
                            check({name, " hold data"}, m_data, exp_d[0]);
                            check({name, " hold index"}, 32'(m_index), 32'(exp_i[0]));
                        end
                        if (abort_idx >= 0 && m_index == abort_idx) begin
                            abort = 1'b1;
                            ready = 1'b1;
                            step();
                            abort = 1'b0;
                            check({name, " abort valid"}, 32'(m_valid), 32'd0);
                            check({name, " abort busy"}, 32'(m_busy), 32'd0);
                            check({name, " abort last"}, 32'(m_last), 32'd0);
                            check({name, " abort done"}, 32'(m_done), 32'd0);
                            step();
                            check({name, " abort no done"}, 32'(m_done), 32'd0);
                            return;
                        end
                        if (poke_idx >= 0 && m_index == poke_idx && !poked && exp_d.size() > 1) begin
                            poked = 1'b1;
                            old = exp_d[1];
                            regs[poke_idx + 1] = 32'hDEAD_BEEF;
                            exp_d[1] = 32'hDEAD_BEEF;
`ifdef REG_DUMP_CHECKSUM_EN
                            exp_d[exp_d.size()-1] = exp_d[exp_d.size()-1] ^ old ^ 32'hDEAD_BEEF;
`endif
                            start = 1'b1;
                        end
                        if (rdy) begin
                            check({name, " data"}, m_data, exp_d[0]);
                            check({name, " index"}, 32'(m_index), 32'(exp_i[0]));
                            check({name, " last"}, 32'(m_last), 32'(exp_l[0]));
                            void'(exp_d.pop_front());
                            void'(exp_i.pop_front());
                            void'(exp_l.pop_front());
                            if (exp_d.size() == 0) last_hs = cyc + 1;
                        end
                    end
                end
                ready = rdy;
                step();
                start = 1'b0;
                cyc++;
            end
        end
        check({name, " words left"}, 32'(exp_d.size()), 32'd0);
        check({name, " done timing"}, 32'(done_cyc), 32'(last_hs));
        check({name, " busy in finish"}, 32'(m_busy), 32'd0);
        if (!rand_ready) check({name, " cycles to last"}, 32'(last_hs), 32'(expect_hs));
        ready = 1'b1;
        step();
        check({name, " done one cycle"}, 32'(m_done), 32'd0);
        check({name, " idle valid"}, 32'(m_valid), 32'd0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0; ready = 1'b0; sel_b = 1'b0;
        for (int i = 0; i < 32; i++) regs[i] = 32'h1000_0000 + 32'(i);
        repeat (2) @(posedge clock);
        #1;
        check("reset busy", 32'(a_busy), 32'd0);
        check("reset done", 32'(a_done), 32'd0);
        check("reset valid", 32'(a_valid), 32'd0);
        check("reset last", 32'(a_last), 32'd0);
        check("reset data", a_data, 32'd0);
        check("reset index", 32'(a_index), 32'd0);
        check("reset rd_sel", 32'(a_sel), 32'd0);
        check("reset rd_sel b", 32'(b_sel), 32'd10);
        reset = 1'b0;
        ready = 1'b1;
        step();

        run_dump("full", 0, 31);

        stall_idx = 3;
        run_dump("stall", 0, 31);
        stall_idx = -1;

        sel_b = 1'b1;
        run_dump("range", 10, 12);
        sel_b = 1'b0;
        step();

        abort_idx = 7;
        run_dump("abort", 0, 31);
        abort_idx = -1;
        run_dump("redump", 0, 31);

        poke_idx = 8;
        run_dump("poke", 0, 31);
        poke_idx = -1;

        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        rand_ready = 1'b1;
        run_dump("random", 0, 31);
        rand_ready = 1'b0;

        start = 1'b1;
        step();
        start = 1'b0;
        repeat (5) step();
        reset = 1'b1;
        #2;
        check("midreset valid", 32'(m_valid), 32'd0);
        check("midreset busy", 32'(m_busy), 32'd0);
        check("midreset data", m_data, 32'd0);
        check("midreset index", 32'(m_index), 32'd0);
        check("midreset rd_sel", 32'(m_sel), 32'd0);
        step();
        reset = 1'b0;
        step();
        check("midreset no done", 32'(m_done), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
